// File: rtl/clock_mode_ctrl.sv
// Mode controller for a digital clock: steps NORMAL -> RESET_SEC -> SET_MIN
// -> SET_HOUR on Set, turns Up presses (and held-Up auto-repeat) into
// minute/hour increment pulses, and drops back to NORMAL after a period of
// inactivity in any settings mode. All outputs are registered.
module clock_mode_ctrl #(
  parameter int TIMEOUT_HALF = 60,
  parameter int REPEAT_DELAY = 2
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Set_Pulse,
  input  logic       i_Up_Pulse,
  input  logic       i_Up_Level,
  input  logic       i_Tick_Half,
  output logic       o_Run,
  output logic       o_Clear_Sec,
  output logic       o_Inc_Min,
  output logic       o_Inc_Hour,
  output logic [3:0] o_Digit_Mask,
  output logic       o_Dot,
  output logic [1:0] o_Mode
);

  localparam int TW = (TIMEOUT_HALF < 2) ? 1 : $clog2(TIMEOUT_HALF + 1);
  localparam int RW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_RESET_SEC = 2'd1,
    ST_SET_MIN   = 2'd2,
    ST_SET_HOUR  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] inact_cnt_reg, inact_cnt_next;
  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
  logic          run_reg, run_next;
  logic          clear_sec_reg, clear_sec_next;
  logic          inc_min_reg, inc_min_next;
  logic          inc_hour_reg, inc_hour_next;
  logic [3:0]    mask_reg, mask_next;
  logic          dot_reg, dot_next;

  logic in_settings;
  logic in_edit;
  logic timeout;
  logic repeat_fire;
  logic inc_req;

  // State, counters and all registered outputs; reset forces the NORMAL display
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg     <= ST_NORMAL;
      inact_cnt_reg <= '0;
      rep_cnt_reg   <= '0;
      run_reg       <= 1'b1;
      clear_sec_reg <= 1'b0;
      inc_min_reg   <= 1'b0;
      inc_hour_reg  <= 1'b0;
      mask_reg      <= 4'b1111;
      dot_reg       <= 1'b1;
    end else begin
      state_reg     <= state_next;
      inact_cnt_reg <= inact_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      run_reg       <= run_next;
      clear_sec_reg <= clear_sec_next;
      inc_min_reg   <= inc_min_next;
      inc_hour_reg  <= inc_hour_next;
      mask_reg      <= mask_next;
      dot_reg       <= dot_next;
    end
  end

  // Next-state, counter and output decode; Set beats timeout, both suppress increments
  always_comb begin
    state_next     = state_reg;
    inact_cnt_next = inact_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    run_next       = 1'b1;
    clear_sec_next = 1'b0;
    inc_min_next   = 1'b0;
    inc_hour_next  = 1'b0;
    mask_next      = 4'b1111;
    dot_next       = dot_reg;

    in_settings = (state_reg != ST_NORMAL);
    in_edit     = (state_reg == ST_SET_MIN) || (state_reg == ST_SET_HOUR);

    // Timeout fires on the tick that would bring the idle count to TIMEOUT_HALF
    timeout = in_settings && i_Tick_Half && !i_Set_Pulse && !i_Up_Pulse &&
              (inact_cnt_reg == TW'(TIMEOUT_HALF - 1));

    if (i_Set_Pulse) begin
      unique case (state_reg)
        ST_NORMAL:    state_next = ST_RESET_SEC;
        ST_RESET_SEC: state_next = ST_SET_MIN;
        ST_SET_MIN:   state_next = ST_SET_HOUR;
        ST_SET_HOUR:  state_next = ST_NORMAL;
        default:      state_next = ST_NORMAL;
      endcase
    end else if (timeout) begin
      state_next = ST_NORMAL;
    end

    // Auto-repeat: once the held count has saturated, every tick is a press
    repeat_fire = in_edit && i_Up_Level && i_Tick_Half &&
                  (rep_cnt_reg >= RW'(REPEAT_DELAY));
    inc_req     = in_edit && !i_Set_Pulse && !timeout && (i_Up_Pulse || repeat_fire);
    inc_min_next  = inc_req && (state_reg == ST_SET_MIN);
    inc_hour_next = inc_req && (state_reg == ST_SET_HOUR);

    if (!in_edit || !i_Up_Level || (state_next != state_reg)) begin
      rep_cnt_next = '0;
    end else if (i_Tick_Half && (rep_cnt_reg < RW'(REPEAT_DELAY))) begin
      rep_cnt_next = rep_cnt_reg + RW'(1);
    end

    if (!in_settings || i_Set_Pulse || i_Up_Pulse || timeout) begin
      inact_cnt_next = '0;
    end else if (i_Tick_Half) begin
      inact_cnt_next = inact_cnt_reg + TW'(1);
    end

    // Outputs follow the state being entered so they change with o_Mode
    unique case (state_next)
      ST_NORMAL: begin
        run_next  = 1'b1;
        mask_next = 4'b1111;
      end
      ST_RESET_SEC: begin
        run_next       = 1'b0;
        clear_sec_next = 1'b1;
        mask_next      = 4'b0000;
      end
      ST_SET_MIN: begin
        run_next  = 1'b0;
        mask_next = 4'b1100;
      end
      ST_SET_HOUR: begin
        run_next  = 1'b0;
        mask_next = 4'b0011;
      end
      default: begin
        run_next  = 1'b1;
        mask_next = 4'b1111;
      end
    endcase

    // Colon blinks only in NORMAL and restarts lit whenever NORMAL is re-entered
    if (state_next != ST_NORMAL) begin
      dot_next = 1'b0;
    end else if (state_reg != ST_NORMAL) begin
      dot_next = 1'b1;
    end else if (i_Tick_Half) begin
      dot_next = ~dot_reg;
    end
  end

  assign o_Mode       = state_reg;
  assign o_Run        = run_reg;
  assign o_Clear_Sec  = clear_sec_reg;
  assign o_Inc_Min    = inc_min_reg;
  assign o_Inc_Hour   = inc_hour_reg;
  assign o_Digit_Mask = mask_reg;
  assign o_Dot        = dot_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: Set cycle, Up increments, auto-repeat,
// inactivity timeout, Set/Up collision and asynchronous reset mid-operation.
module tb_clock_mode_ctrl;

  logic       i_Clock = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Set_Pulse = 1'b0;
  logic       i_Up_Pulse = 1'b0;
  logic       i_Up_Level = 1'b0;
  logic       i_Tick_Half = 1'b0;
  logic       o_Run;
  logic       o_Clear_Sec;
  logic       o_Inc_Min;
  logic       o_Inc_Hour;
  logic [3:0] o_Digit_Mask;
  logic       o_Dot;
  logic [1:0] o_Mode;

  int n_cmp = 0;
  int n_err = 0;
  int min_cnt = 0;
  int hour_cnt = 0;
  logic dual_seen = 1'b0;

  clock_mode_ctrl #(.TIMEOUT_HALF(60), .REPEAT_DELAY(2)) dut (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_Set_Pulse  (i_Set_Pulse),
    .i_Up_Pulse   (i_Up_Pulse),
    .i_Up_Level   (i_Up_Level),
    .i_Tick_Half  (i_Tick_Half),
    .o_Run        (o_Run),
    .o_Clear_Sec  (o_Clear_Sec),
    .o_Inc_Min    (o_Inc_Min),
    .o_Inc_Hour   (o_Inc_Hour),
    .o_Digit_Mask (o_Digit_Mask),
    .o_Dot        (o_Dot),
    .o_Mode       (o_Mode)
  );

  always #5 i_Clock = ~i_Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs observed 1 ns after the rising edge
  task automatic cycle(input logic s, input logic u, input logic l, input logic t);
    @(negedge i_Clock);
    i_Set_Pulse = s;
    i_Up_Pulse  = u;
    i_Up_Level  = l;
    i_Tick_Half = t;
    @(posedge i_Clock);
    #1;
    i_Set_Pulse = 1'b0;
    i_Up_Pulse  = 1'b0;
    i_Tick_Half = 1'b0;
    if (o_Inc_Min)  min_cnt++;
    if (o_Inc_Hour) hour_cnt++;
    if (o_Inc_Min && o_Inc_Hour) dual_seen = 1'b1;
  endtask

  // Tick then one idle cycle, Up level held at l
  task automatic ticks(input int n, input logic l);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b0, l, 1'b1);
      cycle(1'b0, 1'b0, l, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mode"},  {2'b00, o_Mode}, 4'd0);
    chk({pfx, "_run"},   {3'b000, o_Run}, 4'd1);
    chk({pfx, "_clr"},   {3'b000, o_Clear_Sec}, 4'd0);
    chk({pfx, "_imin"},  {3'b000, o_Inc_Min}, 4'd0);
    chk({pfx, "_ihour"}, {3'b000, o_Inc_Hour}, 4'd0);
    chk({pfx, "_mask"},  o_Digit_Mask, 4'b1111);
    chk({pfx, "_dot"},   {3'b000, o_Dot}, 4'd1);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(negedge i_Clock);
    #1;
    chk_reset_vals("rst");
    $display("txn: reset held, mode=%0d mask=%b dot=%0d", o_Mode, o_Digit_Mask, o_Dot);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;

    // Colon blink in NORMAL and Up ignored there
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dot_tick1", {3'b000, o_Dot}, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dot_tick2", {3'b000, o_Dot}, 4'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("normal_up_ign", 4'(min_cnt + hour_cnt), 4'd0);
    $display("txn: NORMAL blink/up-ignore, dot=%0d incs=%0d", o_Dot, min_cnt + hour_cnt);

    // Full Set cycle
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set1_mode", {2'b00, o_Mode}, 4'd1);
    chk("set1_mask", o_Digit_Mask, 4'b0000);
    chk("set1_clr",  {3'b000, o_Clear_Sec}, 4'd1);
    chk("set1_run",  {3'b000, o_Run}, 4'd0);
    chk("set1_dot",  {3'b000, o_Dot}, 4'd0);
    $display("txn: set -> mode=%0d mask=%b clr=%0d", o_Mode, o_Digit_Mask, o_Clear_Sec);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set2_mode", {2'b00, o_Mode}, 4'd2);
    chk("set2_mask", o_Digit_Mask, 4'b1100);
    chk("set2_clr",  {3'b000, o_Clear_Sec}, 4'd0);
    $display("txn: set -> mode=%0d mask=%b clr=%0d", o_Mode, o_Digit_Mask, o_Clear_Sec);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set3_mode", {2'b00, o_Mode}, 4'd3);
    chk("set3_mask", o_Digit_Mask, 4'b0011);
    chk("set3_clr",  {3'b000, o_Clear_Sec}, 4'd0);
    $display("txn: set -> mode=%0d mask=%b clr=%0d", o_Mode, o_Digit_Mask, o_Clear_Sec);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set4_mode", {2'b00, o_Mode}, 4'd0);
    chk("set4_mask", o_Digit_Mask, 4'b1111);
    chk("set4_run",  {3'b000, o_Run}, 4'd1);
    chk("set4_dot",  {3'b000, o_Dot}, 4'd1);
    $display("txn: set -> mode=%0d mask=%b run=%0d", o_Mode, o_Digit_Mask, o_Run);

    // Up presses in SET_MIN
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("min_mode", {2'b00, o_Mode}, 4'd2);
    min_cnt = 0;
    hour_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("up_min_pulse", {3'b000, o_Inc_Min}, 4'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("up_min_one_cycle", {3'b000, o_Inc_Min}, 4'd0);
      $display("txn: up in SET_MIN #%0d, min_cnt=%0d", p + 1, min_cnt);
    end
    chk("up_min_count", 4'(min_cnt), 4'd2);
    chk("up_min_no_hour", 4'(hour_cnt), 4'd0);

    // Set and Up together: Set wins, no increment
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("coll_mode", {2'b00, o_Mode}, 4'd3);
    chk("coll_imin", {3'b000, o_Inc_Min}, 4'd0);
    chk("coll_ihour", {3'b000, o_Inc_Hour}, 4'd0);
    $display("txn: set+up in SET_MIN -> mode=%0d", o_Mode);

    // Auto-repeat in SET_HOUR
    min_cnt = 0;
    hour_cnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rep_first", {3'b000, o_Inc_Hour}, 4'd1);
    ticks(2, 1'b1);
    chk("rep_after2", 4'(hour_cnt), 4'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rep_tick3", {3'b000, o_Inc_Hour}, 4'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rep_total", 4'(hour_cnt), 4'd5);
    chk("rep_no_min", 4'(min_cnt), 4'd0);
    $display("txn: auto-repeat 6 ticks, hour pulses=%0d", hour_cnt);

    // Timeout from SET_MIN after 60 idle ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_enter", {2'b00, o_Mode}, 4'd2);
    min_cnt = 0;
    ticks(59, 1'b0);
    chk("to_59_mode", {2'b00, o_Mode}, 4'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("to_60_mode", {2'b00, o_Mode}, 4'd0);
    chk("to_60_run",  {3'b000, o_Run}, 4'd1);
    chk("to_60_dot",  {3'b000, o_Dot}, 4'd1);
    chk("to_60_noinc", 4'(min_cnt), 4'd0);
    $display("txn: timeout after 60 ticks -> mode=%0d run=%0d", o_Mode, o_Run);

    // Up at tick 59 restarts the inactivity count
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(59, 1'b0);
    chk("restart_mode", {2'b00, o_Mode}, 4'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_to_mode", {2'b00, o_Mode}, 4'd0);
    chk("restart_to_mask", o_Digit_Mask, 4'b1111);
    $display("txn: up at tick 59 restarted timeout, mode=%0d", o_Mode);

    // Asynchronous reset in SET_HOUR while an hour pulse is out
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("prerst_ihour", {3'b000, o_Inc_Hour}, 4'd1);
    chk("prerst_mode", {2'b00, o_Mode}, 4'd3);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    $display("txn: async reset in SET_HOUR -> mode=%0d mask=%b", o_Mode, o_Digit_Mask);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_mode", {2'b00, o_Mode}, 4'd0);

    chk("no_dual_inc", {3'b000, dual_seen}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_HALF, default 60: half-second ticks with no button press before a settings mode returns to NORMAL (60 ticks = 30 s).
REQ-002 SHALL have parameter REPEAT_DELAY, default 2: half-second ticks of Up held before auto-repeat starts.
REQ-003 SHALL have port i_Clock, input, 1 bit: single clock for all logic, rising edge.
REQ-004 SHALL have port i_Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_Set_Pulse, input, 1 bit: debounced Set button; one-cycle pulse per press.
REQ-006 SHALL have port i_Up_Pulse, input, 1 bit: debounced Up button; one-cycle pulse per press.
REQ-007 SHALL have port i_Up_Level, input, 1 bit: debounced Up level; 1 while held.
REQ-008 SHALL have port i_Tick_Half, input, 1 bit: one-cycle strobe at 2 Hz.
REQ-009 SHALL have port o_Run, output, 1 bit: seconds counter enable.
REQ-010 SHALL have port o_Clear_Sec, output, 1 bit: seconds counter synchronous clear.
REQ-011 SHALL have port o_Inc_Min, output, 1 bit: minutes increment pulse, one cycle.
REQ-012 SHALL have port o_Inc_Hour, output, 1 bit: hours increment pulse, one cycle.
REQ-013 SHALL have port o_Digit_Mask, output, 4 bits: display digit enables, [3:2] = minutes, [1:0] = hours.
REQ-014 SHALL have port o_Dot, output, 1 bit: colon/dot segment.
REQ-015 SHALL have port o_Mode, output, 2 bits: state code, 0 = NORMAL, 1 = RESET_SEC, 2 = SET_MIN, 3 = SET_HOUR.

Function
REQ-016 SHALL implement a four-state FSM; each i_Set_Pulse advances it one step, NORMAL -> RESET_SEC -> SET_MIN -> SET_HOUR -> NORMAL, and the new state is visible on the next clock edge.
REQ-017 SHALL drive, registered per state:
- NORMAL: o_Run = 1, o_Digit_Mask = 1111.
- RESET_SEC: o_Run = 0, o_Clear_Sec = 1, o_Digit_Mask = 0000.
- SET_MIN: o_Run = 0, o_Digit_Mask = 1100.
- SET_HOUR: o_Run = 0, o_Digit_Mask = 0011.
REQ-018 SHALL hold o_Dot = 1 on entry to NORMAL, toggle o_Dot on each i_Tick_Half while in NORMAL, and hold o_Dot = 0 in all other states.
REQ-019 SHALL, on i_Up_Pulse, emit exactly one o_Inc_Min pulse in SET_MIN or one o_Inc_Hour pulse in SET_HOUR, asserted on the clock edge after the input pulse.
REQ-020 SHALL ignore i_Up_Pulse and i_Up_Level in NORMAL and RESET_SEC.
REQ-021 SHALL run auto-repeat only in SET_MIN and SET_HOUR, as follows:
- A repeat counter counts i_Tick_Half strobes while i_Up_Level = 1.
- Once the count reaches REPEAT_DELAY, every further i_Tick_Half emits one increment pulse for the current field.
- The counter clears when i_Up_Level = 0 or the state changes.
REQ-022 SHALL clear an inactivity counter on any i_Set_Pulse or i_Up_Pulse, and otherwise increment it on each i_Tick_Half while in RESET_SEC, SET_MIN or SET_HOUR.
REQ-023 SHALL return to NORMAL when the inactivity counter reaches TIMEOUT_HALF, as if Set had cycled through; no increment pulse is emitted on that transition.
REQ-024 SHALL, if i_Set_Pulse and i_Up_Pulse arrive in the same cycle, give Set priority: the state advances and no increment is emitted.
REQ-025 SHALL, if a timeout and i_Set_Pulse occur in the same cycle, give i_Set_Pulse priority.
REQ-026 SHALL never assert o_Inc_Min and o_Inc_Hour in the same cycle, and SHALL emit at most one increment per cycle.
REQ-027 SHALL leave wrap-around of minutes (59 -> 0) and hours (23 -> 0) to the counters; this block only emits pulses.

Reset
REQ-028 SHALL, while i_Reset_n = 0, asynchronously force the following values:
- FSM = NORMAL, o_Mode = 0.
- o_Run = 1, o_Clear_Sec = 0, o_Inc_Min = 0, o_Inc_Hour = 0.
- o_Digit_Mask = 1111, o_Dot = 1.
- Repeat and inactivity counters = 0.
REQ-029 SHALL, when reset is asserted in any settings state, abort that state immediately and output nothing further until the first clock edge after reset is released.

Verification
REQ-030 Bench SHALL cover the Set cycle: 4 x i_Set_Pulse -> o_Mode 0 -> 1 -> 2 -> 3 -> 0, with o_Digit_Mask 1111 -> 0000 -> 1100 -> 0011 -> 1111 and o_Clear_Sec = 1 only in mode 1.
REQ-031 Bench SHALL cover Up in SET_MIN: 2 x i_Up_Pulse -> exactly 2 o_Inc_Min pulses, each 1 cycle late, and o_Inc_Hour = 0 throughout.
REQ-032 Bench SHALL cover auto-repeat: in SET_HOUR, hold i_Up_Level for 6 i_Tick_Half with REPEAT_DELAY = 2 -> 1 pulse from i_Up_Pulse plus 4 repeat pulses on o_Inc_Hour.
REQ-033 Bench SHALL cover timeout: in SET_MIN, apply 60 i_Tick_Half with no buttons -> o_Mode = 0, o_Run = 1, o_Dot = 1; one Up press at tick 59 restarts the count.
REQ-034 Bench SHALL cover simultaneous inputs: i_Set_Pulse and i_Up_Pulse in the same cycle in SET_MIN -> o_Mode = 3 and no increment pulse.
REQ-035 Bench SHALL cover reset mid-operation: assert i_Reset_n = 0 in SET_HOUR between clock edges -> all outputs take reset values immediately, without waiting for a clock edge.
